// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : delay_pkg
//  Purpose  : Shared defaults and FILL/RUN state encoding for the delay line
//  Revision : 1.0  initial release
// ============================================================================
package delay_pkg;

   // Default sample width and buffer address width
   localparam int DELAY_DW = 14;
   localparam int DELAY_AW = 6;

   // Controller states: FILL while priming the buffer, RUN once output is valid
   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage : delay_pkg
`default_nettype wire

// File: rtl/delay_dpram.sv
`default_nettype none
// ============================================================================
//  Module   : delay_dpram
//  Purpose  : Simple dual-port RAM, 2^AW x DW, one write port and one
//             registered read port. Storage itself is never reset; only the
//             read register is, so the output is clean after reset.
//  Revision : 1.0  initial release
// ============================================================================
module delay_dpram #(
   parameter int DW = 14,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   // Write port: storage only, no reset needed
   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; advances only when enabled so the output holds
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= mem[i_raddr];
      end
   end

   assign o_rdata = rdata_q;

endmodule : delay_dpram
`default_nettype wire

// File: rtl/delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : delay_ctrl
//  Purpose  : Programmable sample delay line (1..2^AW-1 accepted samples)
//             built on a circular buffer. A FILL phase primes the buffer
//             after reset or a delay change; RUN streams delayed samples.
//  Options  : DELAY_CTRL_MUTE_EN - force dout to 0 whenever dout_valid=0
//  Revision : 1.0  initial release
// ============================================================================
module delay_ctrl
   import delay_pkg::*;
#(
   parameter int DW = DELAY_DW,
   parameter int AW = DELAY_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          en,
   input  logic [AW-1:0] cfg_delay,
   input  logic          cfg_wr,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          busy,
   output logic [AW-1:0] cur_delay
);

   state_t        state_q,      state_d;
   logic [AW-1:0] cur_delay_q,  cur_delay_d;
   logic [AW-1:0] fill_cnt_q,   fill_cnt_d;
   logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
   logic          dout_valid_q, dout_valid_d;
   logic          busy_q,       busy_d;

   logic [AW-1:0] cfg_sat;
   logic          restart;
   logic [AW-1:0] rd_ptr;
   logic [DW-1:0] ram_rdata;

   // Zero delay is meaningless for a registered read, so clamp it to one
   assign cfg_sat = (cfg_delay == '0) ? {{(AW-1){1'b0}}, 1'b1} : cfg_delay;

   // A rewrite of the active delay while running is a no-op; anything else
   // (new value, or any write during FILL) restarts the fill
   assign restart = cfg_wr && ((state_q == ST_FILL) || (cfg_sat != cur_delay_q));

   // The read pointer trails the write pointer by the applied delay; both
   // wrap naturally in AW bits. Since 1 <= delay < 2^AW it never equals
   // the write address, so there is no read-during-write hazard.
   assign rd_ptr = wr_ptr_q - cur_delay_q;

   // Next-state logic for FSM, fill counter, pointers and output flags
   always_comb begin
      state_d      = state_q;
      cur_delay_d  = cur_delay_q;
      fill_cnt_d   = fill_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      dout_valid_d = dout_valid_q;
      busy_d       = busy_q;

      if (restart) begin
         // The sample accepted on the write cycle is fill sample 1
         state_d      = ST_FILL;
         cur_delay_d  = cfg_sat;
         fill_cnt_d   = {{(AW-1){1'b0}}, en};
         dout_valid_d = 1'b0;
         busy_d       = 1'b1;
      end else if (en && (state_q == ST_FILL)) begin
         // Once D samples are buffered this cycle's read is the first
         // correctly delayed sample, so RUN and valid start together
         if (fill_cnt_q == cur_delay_q) begin
            state_d      = ST_RUN;
            dout_valid_d = 1'b1;
            busy_d       = 1'b0;
         end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
         end
      end

      if (en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   // Control state registers; reset wins over cfg_wr and en
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FILL;
         cur_delay_q  <= {{(AW-1){1'b0}}, 1'b1};
         fill_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         cur_delay_q  <= cur_delay_d;
         fill_cnt_q   <= fill_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
      end
   end

   delay_dpram #(
      .DW (DW),
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (en),
      .i_waddr (wr_ptr_q),
      .i_wdata (din),
      .i_re    (en),
      .i_raddr (rd_ptr),
      .o_rdata (ram_rdata)
   );

`ifdef DELAY_CTRL_MUTE_EN
   assign dout = dout_valid_q ? ram_rdata : '0;
`else
   // Raw read data; may be stale while filling
   assign dout = ram_rdata;
`endif

   assign dout_valid = dout_valid_q;
   assign busy       = busy_q;
   assign cur_delay  = cur_delay_q;

endmodule : delay_ctrl
`default_nettype wire

// File: tb/tb_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_delay_ctrl
//  Purpose  : Scoreboard bench for delay_ctrl. The driver pushes the expected
//             post-edge outputs for every clock; a monitor pops and compares
//             on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_delay_ctrl;

   localparam int DW = 14;
   localparam int AW = 6;
`ifdef DELAY_CTRL_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          cfg_wr = 1'b0;
   logic [DW-1:0] din = '0;
   logic [AW-1:0] cfg_delay = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          busy;
   logic [AW-1:0] cur_delay;

   delay_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .en         (en),
      .cfg_delay  (cfg_delay),
      .cfg_wr     (cfg_wr),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .cur_delay  (cur_delay)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic          chk_d;
      logic [DW-1:0] d;
      logic          busy;
      logic [AW-1:0] cur;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   int            m_d   = 1;     // applied delay
   int            m_n   = 0;     // samples accepted since fill start
   logic          m_lv  = 1'b0;  // last expected dout_valid
   logic [DW-1:0] m_ld  = '0;    // last expected valid dout
   logic [DW-1:0] hist[$];       // every accepted sample, in order
   int            ramp  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Drive one clock of stimulus and queue the expected outputs after the edge
   task automatic step(input logic r, input logic e, input logic w, input logic [AW-1:0] c);
      exp_t          it;
      logic [DW-1:0] s;
      int            sat;
      s = e ? DW'(ramp) : {DW{1'b1}};
      rst = r; en = e; cfg_wr = w; cfg_delay = c; din = s;
      sat = (c == 0) ? 1 : int'(c);
      if (r) begin
         m_d = 1; m_n = 0; m_lv = 1'b0; m_ld = '0;
         it = '{v: 1'b0, chk_d: 1'b1, d: '0, busy: 1'b1, cur: AW'(1)};
      end else begin
         if (w && (sat != m_d || !m_lv)) begin
            m_d = sat; m_n = 0; m_lv = 1'b0;
            if (e) begin
               hist.push_back(s); m_n = 1; ramp++;
            end
            it = '{v: 1'b0, chk_d: MUTE, d: '0, busy: 1'b1, cur: AW'(m_d)};
         end else if (e) begin
            logic          v;
            logic [DW-1:0] d;
            v = (m_n >= m_d);
            d = v ? hist[hist.size() - m_d] : '0;
            hist.push_back(s); m_n++; ramp++;
            m_lv = v;
            if (v) m_ld = d;
            it = '{v: v, chk_d: (v || MUTE), d: d, busy: !v, cur: AW'(m_d)};
         end else begin
            it = '{v: m_lv, chk_d: (m_lv || MUTE), d: (m_lv ? m_ld : '0),
                   busy: !m_lv, cur: AW'(m_d)};
         end
      end
      @(posedge clk);
      sbq.push_back(it);
      #1;
   endtask

   // Monitor: compare every queued expectation on the falling edge
   exp_t mon_it;
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         mon_it = sbq.pop_front();
         check("dout_valid", 32'(dout_valid), 32'(mon_it.v));
         check("busy",       32'(busy),       32'(mon_it.busy));
         check("cur_delay",  32'(cur_delay),  32'(mon_it.cur));
         if (mon_it.chk_d) check("dout", 32'(dout), 32'(mon_it.d));
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      // Default delay 1 with a ramp
      repeat (8) step(0, 1, 0, 0);
      // Hold in RUN on idle cycles
      repeat (2) step(0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0);
      // Delay 10
      step(0, 1, 1, 10);
      repeat (20) step(0, 1, 0, 0);
      // Delay 63 at 50% duty, across pointer wrap
      step(0, 1, 1, 63);
      for (int i = 0; i < 300; i++) step(0, (i % 2) == 1, 0, 0);
      // Restart FILL: delay 20, then 7 after four cycles
      step(0, 1, 1, 20);
      repeat (3) step(0, 1, 0, 0);
      step(0, 1, 1, 7);
      repeat (12) step(0, 1, 0, 0);
      // Same value in RUN is ignored
      step(0, 1, 1, 7);
      repeat (5) step(0, 1, 0, 0);
      // Zero saturates to 1; written on an idle cycle
      step(0, 0, 1, 0);
      repeat (4) step(0, 1, 0, 0);
      // Delay 30, then reset mid-RUN colliding with cfg_wr and en
      step(0, 1, 1, 30);
      repeat (40) step(0, 1, 0, 0);
      step(1, 1, 1, 5);
      repeat (4) step(0, 1, 0, 0);
      en = 1'b0; cfg_wr = 1'b0;
      repeat (3) @(negedge clk);
      check("sb_drain", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_delay_ctrl
`default_nettype wire

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 Parameter DW, default 14, sample width in bits.
REQ-002 Parameter AW, default 6, buffer address width; max delay 2^AW-1 = 63 samples.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  DW  ADC sample stream.
REQ-006 en  input  1  sample strobe; a sample is accepted and the pipeline advances only on cycles with en=1.
REQ-007 cfg_delay  input  AW  requested delay in accepted samples.
REQ-008 cfg_wr  input  1  single-cycle strobe loading cfg_delay.
REQ-009 dout  output  DW  delayed sample.
REQ-010 dout_valid  output  1  dout carries a correctly delayed sample.
REQ-011 busy  output  1  high while in FILL.
REQ-012 cur_delay  output  AW  delay currently applied.

Function
REQ-013 States: FILL and RUN only.
REQ-014 In RUN, on each en=1 cycle, dout at the next edge SHALL equal the din accepted D en-cycles earlier, where D = cur_delay.
REQ-015 Effective delay range 1..63; cfg_delay=0 SHALL be saturated to 1.
REQ-016 en=0 cycles SHALL hold dout, dout_valid, the fill count and the buffer pointers unchanged.
REQ-017 cfg_wr with a value different from cur_delay (after saturation) SHALL update cur_delay on the next edge, clear the fill count, and enter FILL.
REQ-018 cfg_wr in RUN with a value equal to cur_delay SHALL be ignored: no FILL, no glitch on dout_valid.
REQ-019 cfg_wr during FILL SHALL restart FILL with the new value; the fill count SHALL restart from 0.
REQ-020 cfg_wr coincident with en=1 SHALL still accept that din sample into the buffer; that sample counts as fill sample 1 of the new FILL.
REQ-021 FILL SHALL transition to RUN once D samples have been accepted; dout_valid SHALL rise with the first delayed sample, D+1 en-cycles after FILL entry.
REQ-022 In FILL, dout_valid=0 and busy=1; in RUN, busy=0.
REQ-023 Write and read pointers SHALL wrap modulo 2^AW with no skipped or repeated address.

Reset
REQ-024 Reset SHALL set state=FILL, cur_delay=1, the fill count to 0, the pointers to 0, dout=0, dout_valid=0 and busy=1.
REQ-025 Reset asserted mid-FILL or mid-RUN SHALL take priority over cfg_wr and en.
REQ-026 Buffer contents SHALL NOT require reset.

Configuration
REQ-027 Macro DELAY_CTRL_MUTE_EN.
REQ-028 With DELAY_CTRL_MUTE_EN defined, dout SHALL be forced to 0 whenever dout_valid=0.
REQ-029 Without DELAY_CTRL_MUTE_EN, dout in FILL SHALL carry the raw buffer read data, which may be stale; dout_valid is unaffected.

Structure
REQ-030 Package delay_pkg SHALL hold the DW and AW defaults and the FILL/RUN state encoding.
REQ-031 Sub-module delay_dpram: simple dual-port RAM of 2^AW x DW with one write port and one registered read port; the controller instantiates it once.

Verification
REQ-032 Reset, then en=1 constantly with din = a ramp 0,1,2,...: dout_valid rises on the 2nd edge after reset release, and from then on dout = din-1.
REQ-033 cfg_wr with cfg_delay=10, ramp input: busy is high for 10 en-cycles; then dout_valid=1 and dout = din-10 steadily.
REQ-034 cfg_delay=63 at 50% en duty, ramp input: delay is 63 accepted samples, no value is skipped or repeated across pointer wrap, and dout holds on en=0 cycles.
REQ-035 Second cfg_wr (7) 4 cycles into a FILL for delay 20: FILL restarts, dout_valid rises 8 en-cycles after the second cfg_wr, and cur_delay=7.
REQ-036 cfg_wr with the value equal to cur_delay in RUN: dout_valid stays 1 and there is no discontinuity in dout; cfg_wr with 0 gives cur_delay=1.
REQ-037 rst asserted mid-RUN at delay 30: next edge gives dout=0, dout_valid=0 and cur_delay=1; with DELAY_CTRL_MUTE_EN defined, dout=0 throughout FILL.
